serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first, one bit per clock.
- Each bit uses the team's half_adder cell pair plus a registered carry, i.e. sum = a^b^c.
- Sits directly downstream of half_adder: consumes its sum/carry outputs and closes the carry loop through a flip-flop.
- Trades latency for area in datapaths where a full parallel ripple adder is too large.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; sampled on rising clk only.
- start  input  1  request to begin an addition; accepted only when ready=1.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  block is IDLE and can accept start.
- busy  output  1  addition in progress (state RUN).
- done  output  1  one-cycle pulse: sum/carry hold a new result.
- sum  output  WIDTH  result bits; held until the next completion.
- carry  output  1  carry-out of the MSB; held with sum.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). No asynchronous logic.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; ready=1, busy=0, done=0, sum=0, carry=0.
  - Internal shift registers, carry flop and bit counter cleared.
- States:
  - IDLE: ready=1. start=1 at an edge latches a, b into shift registers and cin into the carry flop, clears the counter, then goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1, ready=0. Every edge:
    - computes s = a_sr[0]^b_sr[0]^c and c' = (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])) via two half_adder stages plus OR.
    - shifts a_sr/b_sr right by one; shifts s into the MSB of the result shift register; counter++.
    - On the edge where the counter reaches WIDTH-1 (the WIDTH-th bit), copies the result register to sum and c' to carry, then goes to DONE.
  - DONE: done=1 for exactly one cycle, ready=0, busy=0. Next edge goes to IDLE unconditionally.
- Latency:
  - start accepted at edge E0 → done high in the cycle following edge E(WIDTH).
  - ready returns after edge E(WIDTH+1).
  - Throughput is one result per WIDTH+2 cycles.
- Handshake and timing rules:
  - start while ready=0 (RUN or DONE) is ignored and is not queued.
  - Changes on a/b/cin after the accepting edge have no effect.
- Output holding:
  - sum/carry change only on the completing edge (and on reset).
  - Partial results are never visible on sum/carry.
- Arithmetic: {carry,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: the rst_n=0 edge aborts RUN/DONE immediately; all outputs take reset values; no done pulse.
- Simultaneous events: rst_n=0 together with start=1 → reset wins and start is dropped.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1 loads ~b into b_sr and forces the carry flop to 1, ignoring cin. Result is a-b; carry=1 means no borrow (a>=b unsigned).
  - sub=0 behaves exactly as an add.
- Undefined: port sub absent; add only; logic identical to the base block.

Test Plan (WIDTH=8):
- Reset then idle: rst_n=0 for 2 cycles → ready=1, busy=0, done=0, sum=0x00, carry=0.
- Basic add: a=0x5A, b=0x33, cin=0, start for 1 cycle → busy for 8 cycles, then done pulse with sum=0x8D, carry=0; ready high one cycle later.
- Carry chain: a=0xFF, b=0x01, cin=0 → sum=0x00, carry=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, carry=1.
- Busy start ignored: start pulsed 3 cycles after the accepting edge with a=0x01, b=0x01 → first result unchanged, exactly one done pulse, ready=1 afterward.
- Reset mid-run: rst_n=0 at bit 4 of 0xAA+0x55 → no done pulse, sum=0x00, carry=0, ready=1 after the reset edge. A new add of 0x01+0x02 then gives sum=0x03.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x10, b=0x01 → sum=0x0F, carry=1.
  - sub=1, a=0x00, b=0x01 → sum=0xFF, carry=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock: {carry,sum} = a + b + cin.
// Optional subtract mode (port sub) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_ha0_s, w_ha0_c, w_ha1_s, w_ha1_c, w_cout;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Two half-adder stages plus OR form the full-adder bit cell.
  assign w_ha0_s = r_a_sr[0] ^ r_b_sr[0];
  assign w_ha0_c = r_a_sr[0] & r_b_sr[0];
  assign w_ha1_s = w_ha0_s ^ r_c;
  assign w_ha1_c = w_ha0_s & r_c;
  assign w_cout  = w_ha0_c | w_ha1_c;

  // The stored partial result lacks its LSB slot: the oldest bit falls out as the final bit enters.
  assign w_res_next = {w_ha1_s, r_res};

`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_c     <= w_c_load;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_c    <= w_cout;
          r_res  <= w_res_next[WIDTH-1:1];
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_res_next;
            r_carry <= w_cout;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Subtract vectors are exercised only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  last_sum;
  logic        last_carry;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block idle again.
  task automatic run_add(input string tag, input logic [7:0] ta, input logic [7:0] tb_in,
                         input logic tc, input logic [7:0] es, input logic ec);
    int unsigned busy_cnt;
    bit          seen;
    a     = ta;
    b     = tb_in;
    cin   = tc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = 8'h5C;
    cin   = ~tc;
    @(negedge clk);
    check_eq({tag, "_busy0"},  {30'd0, busy, ready}, 32'h2);
    check_eq({tag, "_held"},   {23'd0, carry, sum}, {23'd0, last_carry, last_sum});
    busy_cnt = 0;
    seen     = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check_eq({tag, "_sum"},   {24'd0, sum}, {24'd0, es});
    check_eq({tag, "_carry"}, {31'd0, carry}, {31'd0, ec});
    check_eq({tag, "_done_rdy_busy"}, {30'd0, ready, busy}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_after"}, {29'd0, done, ready, busy}, 32'h2);
    last_sum   = es;
    last_carry = ec;
  endtask

  initial begin
    int unsigned n_done;
    logic [7:0]  cap_sum;
    logic        cap_carry;
    n_checks   = 0;
    n_fail     = 0;
    last_sum   = 8'h00;
    last_carry = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    // Reset with start asserted: reset must win.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_flags", {29'd0, ready, busy, done}, 32'h4);
    check_eq("reset_result", {23'd0, carry, sum}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_flags", {29'd0, ready, busy, done}, 32'h4);

    run_add("basic",  8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_add("chain1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add("chain2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start during RUN must be ignored, not queued.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    n_done    = 0;
    cap_sum   = 8'h00;
    cap_carry = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        cap_sum   = sum;
        cap_carry = carry;
      end
      if (i == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (i == 4) start = 1'b0;
    end
    check_eq("ignore_done_count", n_done, 32'd1);
    check_eq("ignore_sum", {23'd0, cap_carry, cap_sum}, 32'h046);
    check_eq("ignore_ready", {30'd0, ready, busy}, 32'h2);

    // Reset mid-run aborts without a done pulse.
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_flags", {29'd0, ready, busy, done}, 32'h4);
    check_eq("midrst_result", {23'd0, carry, sum}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("midrst_no_done", n_done, 32'd0);
    last_sum   = 8'h00;
    last_carry = 1'b0;
    run_add("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_add("sub1", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_add("sub2", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
    sub = 1'b0;
    run_add("sub_off", 8'h10, 8'h01, 1'b1, 8'h12, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
